pkt_ingress: RTL and testbench
==============================

PKT_INGRESS -- requirements
Module: pkt_ingress

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, packet word width (matches `DATA_WIDTH in def.v).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, word-address width; buffer depth D = 2^ADDR_WIDTH.
REQ-003 SHALL have parameter DESC_DEPTH, default 4 (power of two), descriptor queue entries.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  ingress word valid.
REQ-007 SHALL have port in_data  input  DATA_WIDTH  ingress word.
REQ-008 SHALL have port in_last  input  1  final word of packet.
REQ-009 SHALL have port in_ready  output  1  ingress accept; word transfers when in_valid && in_ready.
REQ-010 SHALL have port addr_i  input  ADDR_WIDTH  switch read address (tag_addr).
REQ-011 SHALL have port data_o  output  DATA_WIDTH  read data to switch (tag_data).
REQ-012 SHALL have ports desc_valid output 1, desc_start output ADDR_WIDTH, desc_len output ADDR_WIDTH+1: head committed-packet descriptor.
REQ-013 SHALL have port desc_ready  input  1  pops descriptor when desc_valid && desc_ready.
REQ-014 SHALL have port rel  input  1  one-cycle pulse freeing buffer space of oldest popped, unreleased packet.
REQ-015 SHALL have port drop_cnt  output  16  dropped-packet counter.

Function
REQ-016 SHALL store words in internal circular RAM of D words; write pointer wp, release pointer rp, used count U (0..D).
REQ-017 SHALL register data_o <= mem[addr_i] every cycle (1-cycle latency); same-cycle write to same address returns old data.
REQ-018 SHALL implement FSM IDLE, RECV, DROP.
REQ-019 IDLE: in_ready = 1 iff descriptor queue not full and U < D; accepted word records start = wp, enters RECV (or commits immediately if in_last).
REQ-020 RECV: in_ready = 1; each accepted word written at wp, wp increments modulo D, U increments.
REQ-021 Accepted word with in_last SHALL commit descriptor {start, len} (len = word count, 1..D) and return to IDLE.
REQ-022 Accepted non-last word that makes U = D SHALL abort: wp rewinds to start, U reduced by words written so far, state DROP.
REQ-023 DROP: in_ready = 1, words discarded, no writes; accepted in_last returns to IDLE and increments drop_cnt (saturating at 0xFFFF).
REQ-024 Committed descriptor SHALL appear on desc_valid/desc_start/desc_len the cycle after commit; head holds stable until popped.
REQ-025 Descriptor queue SHALL keep write, read (pop) and release indices; popped entries remain until released.
REQ-026 Queue full = DESC_DEPTH entries not yet released; IDLE in_ready SHALL be 0 while full.
REQ-027 rel with at least one popped-unreleased entry SHALL advance rp by that entry's len and reduce U by len; rel otherwise ignored.
REQ-028 Same-cycle word write and rel SHALL both apply: U_next = U + 1 - len.
REQ-029 Same-cycle commit and pop of an empty queue SHALL not bypass; pop takes effect on the following visible descriptor.
REQ-030 Pointer arithmetic SHALL wrap modulo D; packets may straddle address D-1 to 0.

Reset
REQ-031 rst SHALL set state IDLE, wp = rp = 0, U = 0, queue empty, desc_valid = 0, desc_start = 0, desc_len = 0, data_o = 0, drop_cnt = 0; RAM contents not cleared.
REQ-032 rst mid-packet SHALL discard in-progress and all queued packets without counting drops; in_ready = 1 the cycle after rst deasserts.

Verification
REQ-033 Send 3-word packet A,B,C from empty -> desc_valid next cycle, desc_start=0, desc_len=3; addr_i=1 -> data_o=B one cycle later.
REQ-034 ADDR_WIDTH=4: fill 14 words, pop and rel, then 5-word packet -> desc_start=14, words at 14,15,0,1,2.
REQ-035 ADDR_WIDTH=4, empty, 20-word packet -> drop at word 16, drop_cnt=1, no descriptor, U=0, wp=0.
REQ-036 Commit 4 one-word packets, none released -> in_ready=0 in IDLE; pop then rel -> in_ready=1 next cycle.
REQ-037 Write word while rel of 3-word packet with U=5 -> U=3.
REQ-038 Assert rst after 2 words of a packet -> desc_valid=0, drop_cnt=0, next packet desc_start=0.

Source files
------------

// File: rtl/pkt_ingress.sv
// Packet ingress buffer: stores words in a circular RAM, commits per-packet descriptors,
// drops packets that cannot fit, and frees space on release pulses from the switch.
module pkt_ingress #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DESC_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  desc_valid,
  output logic [ADDR_WIDTH-1:0] desc_start,
  output logic [ADDR_WIDTH:0]   desc_len,
  input  logic                  desc_ready,
  input  logic                  rel,
  output logic [15:0]           drop_cnt
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;
  localparam int unsigned QIdxW = $clog2(DESC_DEPTH);
  localparam int unsigned QPtrW = QIdxW + 1;
  localparam logic [ADDR_WIDTH:0] FullCount = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {StIdle, StRecv, StDrop} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wp_q, wp_d;
  logic [ADDR_WIDTH-1:0] rp_q, rp_d;
  logic [ADDR_WIDTH:0]   used_q, used_d;
  logic [ADDR_WIDTH-1:0] start_q, start_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [15:0]           drop_q, drop_d;

  logic [DATA_WIDTH-1:0] mem [Depth];

  logic [ADDR_WIDTH-1:0] q_start [DESC_DEPTH];
  logic [ADDR_WIDTH:0]   q_len   [DESC_DEPTH];
  logic [QPtrW-1:0]      q_wr_q, q_rd_q, q_rel_q;

  logic                  accept;
  logic                  wr_en;
  logic                  commit;
  logic                  pop;
  logic                  rel_ok;
  logic                  q_full;
  logic [ADDR_WIDTH-1:0] pkt_start;
  logic [ADDR_WIDTH:0]   words_before;
  logic [ADDR_WIDTH:0]   commit_len;
  logic [ADDR_WIDTH:0]   rel_len;

  // Entries stay counted against the queue until released, not just until popped.
  assign q_full     = (q_wr_q - q_rel_q) == QPtrW'(DESC_DEPTH);
  assign desc_valid = q_wr_q != q_rd_q;
  assign pop        = desc_valid && desc_ready;
  assign rel_ok     = rel && (q_rd_q != q_rel_q);
  assign rel_len    = q_len[q_rel_q[QIdxW-1:0]];
  assign desc_start = desc_valid ? q_start[q_rd_q[QIdxW-1:0]] : '0;
  assign desc_len   = desc_valid ? q_len[q_rd_q[QIdxW-1:0]] : '0;

  assign pkt_start    = (state_q == StIdle) ? wp_q : start_q;
  assign words_before = (state_q == StIdle) ? '0 : cnt_q;
  assign commit_len   = words_before + 1'b1;
  assign drop_cnt     = drop_q;

  always_comb begin
    state_d  = state_q;
    wp_d     = wp_q;
    used_d   = used_q;
    start_d  = start_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;
    wr_en    = 1'b0;
    commit   = 1'b0;
    in_ready = (state_q == StIdle) ? (!q_full && (used_q != FullCount)) : 1'b1;
    accept   = in_valid && in_ready;

    if (accept) begin
      if (state_q == StDrop) begin
        if (in_last) begin
          state_d = StIdle;
          if (drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
          end
        end
      end else begin
        wr_en = 1'b1;
        if (in_last) begin
          commit  = 1'b1;
          wp_d    = wp_q + 1'b1;
          used_d  = used_q + 1'b1;
          state_d = StIdle;
        end else if ((used_q + 1'b1) == FullCount) begin
          // Packet cannot fit: give back everything it wrote, including this word.
          wp_d    = pkt_start;
          used_d  = used_q - words_before;
          state_d = StDrop;
        end else begin
          wp_d    = wp_q + 1'b1;
          used_d  = used_q + 1'b1;
          start_d = pkt_start;
          cnt_d   = commit_len;
          state_d = StRecv;
        end
      end
    end

    if (rel_ok) begin
      used_d = used_d - rel_len;
    end
    rp_d = rel_ok ? (rp_q + rel_len[ADDR_WIDTH-1:0]) : rp_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      wp_q    <= '0;
      rp_q    <= '0;
      used_q  <= '0;
      start_q <= '0;
      cnt_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      used_q  <= used_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_wr_q  <= '0;
      q_rd_q  <= '0;
      q_rel_q <= '0;
    end else begin
      if (commit) begin
        q_wr_q <= q_wr_q + 1'b1;
      end
      if (pop) begin
        q_rd_q <= q_rd_q + 1'b1;
      end
      if (rel_ok) begin
        q_rel_q <= q_rel_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      q_start[q_wr_q[QIdxW-1:0]] <= pkt_start;
      q_len[q_wr_q[QIdxW-1:0]]   <= commit_len;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wp_q] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_o <= '0;
    end else begin
      data_o <= mem[addr_i];
    end
  end

  // Occupancy always equals the distance from release pointer to write pointer.
  ring_consistent_a: assert property (@(posedge clk) disable iff (rst)
    (wp_q - rp_q) == used_q[ADDR_WIDTH-1:0]);

endmodule

// File: tb/tb_pkt_ingress.sv
// Randomised bench for pkt_ingress with a packet-level reference model plus directed scenarios.
module tb_pkt_ingress;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int DD = 4;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [AW-1:0] addr_i = '0;
  logic [DW-1:0] data_o;
  logic          desc_valid;
  logic [AW-1:0] desc_start;
  logic [AW:0]   desc_len;
  logic          desc_ready = 1'b0;
  logic          rel = 1'b0;
  logic [15:0]   drop_cnt;

  pkt_ingress #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DESC_DEPTH(DD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .addr_i     (addr_i),
    .data_o     (data_o),
    .desc_valid (desc_valid),
    .desc_start (desc_start),
    .desc_len   (desc_len),
    .desc_ready (desc_ready),
    .rel        (rel),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int start;
    int len;
  } desc_t;

  // Reference model: committed packets as descriptor lists, in-flight packet as a word list.
  desc_t         vis_q[$];
  desc_t         pop_q[$];
  logic [DW-1:0] cur_q[$];
  logic [DW-1:0] mem_m [D];
  int            cur_start;
  int            wp_m;
  int            u_m;
  int            drop_m;
  bit            dropping;
  bit            exp_known;
  logic [DW-1:0] exp_data;

  int n_checks = 0;
  int n_errors = 0;
  int rel_pct;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    if (dropping || cur_q.size() != 0) return 1'b1;
    return ((vis_q.size() + pop_q.size()) < DD) && (u_m < D);
  endfunction

  function automatic bit in_committed(input int a);
    foreach (vis_q[i]) if (((a - vis_q[i].start) & (D - 1)) < vis_q[i].len) return 1'b1;
    foreach (pop_q[i]) if (((a - pop_q[i].start) & (D - 1)) < pop_q[i].len) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    vis_q.delete();
    pop_q.delete();
    cur_q.delete();
    wp_m      = 0;
    u_m       = 0;
    drop_m    = 0;
    dropping  = 1'b0;
    exp_known = 1'b1;
    exp_data  = '0;
  endtask

  task automatic model_update(input bit v, input logic [DW-1:0] d, input bit l, input bit dr,
                              input bit r, input logic [AW-1:0] a);
    bit    acc;
    bit    rel_ok;
    bit    pop_ok;
    desc_t nd;
    acc    = v && model_ready();
    rel_ok = r && (pop_q.size() != 0);
    pop_ok = dr && (vis_q.size() != 0);
    exp_known = in_committed(int'(a));
    exp_data  = mem_m[a];
    if (acc) begin
      if (dropping) begin
        if (l) begin
          dropping = 1'b0;
          if (drop_m < 65535) drop_m++;
        end
      end else begin
        if (cur_q.size() == 0) cur_start = wp_m;
        cur_q.push_back(d);
        if (l) begin
          foreach (cur_q[i]) mem_m[(cur_start + i) % D] = cur_q[i];
          nd.start = cur_start;
          nd.len   = cur_q.size();
          vis_q.push_back(nd);
          wp_m = (cur_start + nd.len) % D;
          u_m += nd.len;
          cur_q.delete();
        end else if (u_m + cur_q.size() == D) begin
          cur_q.delete();
          dropping = 1'b1;
        end
      end
    end
    if (rel_ok) begin
      nd = pop_q.pop_front();
      u_m -= nd.len;
    end
    if (pop_ok) pop_q.push_back(vis_q.pop_front());
  endtask

  task automatic check_outputs();
    check_eq("in_ready", in_ready, model_ready());
    check_eq("desc_valid", desc_valid, vis_q.size() != 0);
    check_eq("desc_start", desc_start, (vis_q.size() != 0) ? vis_q[0].start : 0);
    check_eq("desc_len", desc_len, (vis_q.size() != 0) ? vis_q[0].len : 0);
    check_eq("drop_cnt", drop_cnt, drop_m);
    if (exp_known) check_eq("data_o", data_o, exp_data);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit l, input bit dr,
                      input bit r, input logic [AW-1:0] a);
    in_valid   = v;
    in_data    = d;
    in_last    = l;
    desc_ready = dr;
    rel        = r;
    addr_i     = a;
    #1;
    check_outputs();
    model_update(v, d, l, dr, r, a);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic send_pkt(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) step(1'b1, base + DW'(i), i == n - 1, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    desc_ready = 1'b0;
    rel        = 1'b0;
    addr_i     = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [AW-1:0] rd_addr [5];
    @(negedge clk);
    do_reset();
    check_eq("reset_in_ready", in_ready, 1);
    check_eq("reset_drop_cnt", drop_cnt, 0);

    // Three-word packet from empty, then read back word B.
    step(1'b1, 32'hA, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 32'hB, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 32'hC, 1'b1, 1'b0, 1'b0, '0);
    check_eq("p3_valid", desc_valid, 1);
    check_eq("p3_start", desc_start, 0);
    check_eq("p3_len", desc_len, 3);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd1);
    check_eq("p3_read_b", data_o, 32'hB);

    // Packet straddling the end of the ring.
    do_reset();
    send_pkt(14, 32'h1400);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, '0);
    send_pkt(5, 32'h5000);
    check_eq("wrap_start", desc_start, 14);
    check_eq("wrap_len", desc_len, 5);
    rd_addr = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd2};
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, rd_addr[i]);
      check_eq("wrap_data", data_o, 32'h5000 + DW'(i));
    end

    // Oversized packet is dropped without leaving residue.
    do_reset();
    send_pkt(20, 32'h2000);
    check_eq("drop_cnt_1", drop_cnt, 1);
    check_eq("drop_no_desc", desc_valid, 0);
    check_eq("drop_ready", in_ready, 1);
    send_pkt(1, 32'h77);
    check_eq("drop_next_start", desc_start, 0);

    // Descriptor queue full until a popped entry is released.
    do_reset();
    for (int i = 0; i < 4; i++) send_pkt(1, 32'h100 + DW'(i));
    check_eq("qfull_ready", in_ready, 0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    check_eq("qfull_popped_ready", in_ready, 0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, '0);
    check_eq("qfull_rel_ready", in_ready, 1);

    // Word write coinciding with release of a 3-word packet.
    do_reset();
    send_pkt(3, 32'h300);
    send_pkt(2, 32'h400);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 32'h500, 1'b0, 1'b0, 1'b1, '0);
    for (int i = 1; i < 14; i++) step(1'b1, 32'h500 + DW'(i), i == 13, 1'b0, 1'b0, '0);
    check_eq("relw_drop_cnt", drop_cnt, 0);
    check_eq("relw_full_ready", in_ready, 0);
    check_eq("relw_head_start", desc_start, 3);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    check_eq("relw_p3_start", desc_start, 5);
    check_eq("relw_p3_len", desc_len, 14);

    // Reset in the middle of a packet discards everything.
    do_reset();
    send_pkt(3, 32'h600);
    step(1'b1, 32'h700, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 32'h701, 1'b0, 1'b0, 1'b0, '0);
    do_reset();
    check_eq("mid_rst_valid", desc_valid, 0);
    check_eq("mid_rst_drop", drop_cnt, 0);
    check_eq("mid_rst_ready", in_ready, 1);
    send_pkt(1, 32'h800);
    check_eq("mid_rst_start", desc_start, 0);
    check_eq("mid_rst_len", desc_len, 1);

    // Random traffic: sparse releases first (fill/drop pressure), then frequent releases.
    for (int i = 0; i < 4000; i++) begin
      rel_pct = (i < 2000) ? 10 : 45;
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 99) < 75, $urandom, $urandom_range(0, 5) == 0,
             $urandom_range(0, 99) < 40, $urandom_range(0, 99) < rel_pct,
             AW'($urandom_range(0, D - 1)));
      end
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
